upa2_coeff_update: RTL and testbench
====================================

Name: upa2_coeff_update

Overview:
- Combinational G.726 ADPCM second-order pole predictor coefficient update (UPA2).
- Computes the unlimited new A2 coefficient A2T from the current coefficients A1/A2, the partial-signal sign bits PK0/PK1/PK2, and SIGPK.
- Sits in the adaptive predictor datapath; its output feeds the A2 limiter (LIMC).
- Carries scan-test ports for DFT insertion.

Parameters:
- None. All widths are fixed by G.726.

Ports:
- clk  input  1  system clock; used only by the scan chain or the optional output register
- reset  input  1  asynchronous active-low reset
- scan_in0..scan_in4  input  1 each  scan chain inputs
- scan_enable  input  1  scan shift enable
- test_mode  input  1  DFT test mode
- PK0  input  1  sign of current partial reconstructed signal
- PK1  input  1  sign of PK delayed 1 sample
- PK2  input  1  sign of PK delayed 2 samples
- A1  input  16  current first-order coefficient, two's complement
- A2  input  16  current second-order coefficient, two's complement
- SIGPK  input  1  1 when the partial signal is zero (sign update suppressed)
- scan_out0..scan_out4  output  1 each  scan chain outputs; driven 0 in functional RTL
- A2T  output  16  unlimited updated A2 coefficient

Behaviour:
- Default build is purely combinational. A2T settles within the same clock period as the input change; the bench checks it half a cycle after applying inputs.
- reset and clk do not affect A2T in the default build. The design must work with reset held low permanently.
- All arithmetic is unsigned modular; masks are shown at each step.
- PKS1 = PK0 ^ PK1; PKS2 = PK0 ^ PK2.
- UGA2A (17b) = PKS2 ? 114688 : 16384.
- FA1 (17b) selection:
  - A1[15]=0: A1<=8191 ? A1<<2 : 32764.
  - A1[15]=1: A1>=57345 ? (A1<<2)&0x1FFFF : 98308.
- FA = PKS1 ? FA1 : (131072-FA1)&0x1FFFF.
- UGA2B = (UGA2A+FA)&0x1FFFF; UGA2S = UGA2B[16].
- UGA2 (16b):
  - SIGPK=1: 0.
  - SIGPK=0, UGA2S=0: UGA2B>>7.
  - SIGPK=0, UGA2S=1: (UGA2B>>7)+0xFC00, i.e. sign extension of the 10-bit value.
- ULA2 (16b):
  - A2[15]=0: (65536-(A2>>7))&0xFFFF.
  - A2[15]=1: (65536-((A2>>7)+65024))&0xFFFF, i.e. arithmetic shift.
- UA2 = (UGA2+ULA2)&0xFFFF; A2T = (A2+UA2)&0xFFFF.
- No limiting is applied here; overflow wraps modulo 2^16.
- Boundary values:
  - A1=8191 and A1=57345 are pass-through (not clamped).
  - A1=8192 clamps to 32764.
  - A1=57344 clamps to 98308.
- X/Z on any data input may propagate to A2T. No other state exists.

Optional Feature:
- UPA2_OUTREG_EN defined:
  - A2T is registered on posedge clk with 1-cycle latency.
  - Asynchronous clear to 0x0000 while reset=0.
  - The combinational value is captured when reset=1.
- Undefined (default): A2T is purely combinational with 0 latency; no flops in the design.

Test Plan:
- PK0=PK1=PK2=0, SIGPK=0, A1=0x0000, A2=0x0000 -> A2T=0x0080.
- Same inputs with SIGPK=1 -> A2T=0x0000 (gradient term suppressed).
- PK0=1, PK1=PK2=0, SIGPK=0, A1=0, A2=0 -> A2T=0xFF80 (negative UGA2 sign extension).
- PK0=PK1=PK2=0, SIGPK=0, A1=0x1000, A2=0x1000 -> A2T=0x0FE0 (leak term, UGA2B wraps to 0).
- SIGPK=1, A2=0xF000 (negative) -> A2T=0xF020 (negative-leak path).
- PK all 0, SIGPK=0, A1=0x4000 (clamped to 32764), A2=0 -> A2T=0xFF80.
- Also sweep the A1 boundaries 8191/8192/57344/57345 against the reference model.

Source files
------------

// File: rtl/upa2_coeff_update_if.sv
// Data bundle for the G.726 UPA2 coefficient update: sign bits, coefficients, result.
// Latency: none, this is a plain signal bundle.
// Backpressure: none, values are sampled every cycle with no handshake.
interface upa2_coeff_update_if;
    logic        PK0;
    logic        PK1;
    logic        PK2;
    logic        SIGPK;
    logic [15:0] A1;
    logic [15:0] A2;
    logic [15:0] A2T;

    // Predictor side: drives the operands and consumes the unlimited A2T.
    modport master (
        output PK0, PK1, PK2, SIGPK, A1, A2,
        input  A2T
    );

    // Update block side: consumes the operands and produces A2T.
    modport slave (
        input  PK0, PK1, PK2, SIGPK, A1, A2,
        output A2T
    );
endinterface

// File: rtl/upa2_coeff_update.sv
// G.726 UPA2: unlimited second-order pole coefficient update A2T (feeds LIMC). Optional macro: UPA2_OUTREG_EN.
// Latency: 0 cycles (combinational); 1 cycle when UPA2_OUTREG_EN registers A2T.
// Backpressure: none; a new result is produced for every input set.
module upa2_coeff_update (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scan_in0,
    input  logic                       scan_in1,
    input  logic                       scan_in2,
    input  logic                       scan_in3,
    input  logic                       scan_in4,
    input  logic                       scan_enable,
    input  logic                       test_mode,
    output logic                       scan_out0,
    output logic                       scan_out1,
    output logic                       scan_out2,
    output logic                       scan_out3,
    output logic                       scan_out4,
    upa2_coeff_update_if.slave         coef
);

    logic        pks1;
    logic        pks2;
    logic [16:0] uga2a;
    logic [16:0] a1_shl;
    logic [16:0] fa1;
    logic [16:0] fa;
    logic [16:0] uga2b;
    logic        uga2s;
    logic [15:0] uga2;
    logic [15:0] a2_asr;
    logic [15:0] ula2;
    logic [15:0] ua2;
    logic [15:0] a2t_d;

    // Scan chain is stitched in by DFT insertion; functionally the outputs are tied low.
    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    // DFT inputs only matter after scan insertion; collected here so they are not left dangling.
    logic unused_dft;
    assign unused_dft = ^{clk, reset, scan_in0, scan_in1, scan_in2, scan_in3,
                          scan_in4, scan_enable, test_mode};

    // Gradient term: sign-correlation of PK history scaled by a clamped copy of A1.
    always_comb begin
        pks1   = coef.PK0 ^ coef.PK1;
        pks2   = coef.PK0 ^ coef.PK2;
        uga2a  = pks2 ? 17'd114688 : 17'd16384;
        a1_shl = {coef.A1[14:0], 2'b00};
        fa1    = 17'd0;
        if (!coef.A1[15]) begin
            // Positive A1 saturates at +0.5 (8191 still passes through unchanged).
            fa1 = (coef.A1 <= 16'd8191) ? a1_shl : 17'd32764;
        end else begin
            // Negative A1 saturates at -0.5 (57345 still passes through unchanged).
            fa1 = (coef.A1 >= 16'd57345) ? a1_shl : 17'd98308;
        end
        fa    = pks1 ? fa1 : (17'd0 - fa1);
        uga2b = uga2a + fa;
        uga2s = uga2b[16];
        uga2  = 16'd0;
        if (!coef.SIGPK) begin
            // Scale by 2^-7 and sign-extend the 10-bit result to 16 bits.
            uga2 = {{6{uga2s}}, uga2b[16:7]};
        end
    end

    // Leak term: subtract A2 scaled by 2^-7 (arithmetic shift), then accumulate onto A2.
    always_comb begin
        a2_asr = {{7{coef.A2[15]}}, coef.A2[15:7]};
        ula2   = 16'd0 - a2_asr;
        ua2    = uga2 + ula2;
        a2t_d  = coef.A2 + ua2;
    end

`ifdef UPA2_OUTREG_EN
    logic [15:0] a2t_q;

    // Optional output register: cleared while reset is low, captures the update otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a2t_q <= 16'h0000;
        end else begin
            a2t_q <= a2t_d;
        end
    end

    assign coef.A2T = a2t_q;
`else
    assign coef.A2T = a2t_d;
`endif

endmodule

// File: tb/tb_upa2_coeff_update.sv
// Self-checking bench for upa2_coeff_update: directed vectors plus an arithmetic reference model.
// Latency: expects the combinational build, A2T checked half a cycle after inputs change.
// Backpressure: not applicable.
module tb_upa2_coeff_update;

    logic clk = 1'b0;
    logic reset;
    logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic scan_enable, test_mode;
    logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    upa2_coeff_update_if bus ();

    upa2_coeff_update dut (
        .clk         (clk),
        .reset       (reset),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4),
        .coef        (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          vec_vld = 1'b0;
    bit          lit_vld = 1'b0;
    logic [15:0] lit_exp;
    logic [15:0] mdl;
    string       tag = "idle";

    // Reference: G.726 UPA2 written as plain integer arithmetic with explicit moduli.
    function automatic logic [15:0] model(input int pk0, input int pk1, input int pk2,
                                          input int sigpk, input int a1, input int a2);
        int pks1, pks2, uga2a, fa1, fa, uga2b, uga2, ula2, ua2;
        pks1  = pk0 ^ pk1;
        pks2  = pk0 ^ pk2;
        uga2a = (pks2 != 0) ? 114688 : 16384;
        if (a1 < 32768) fa1 = (a1 <= 8191) ? a1 * 4 : 32764;
        else            fa1 = (a1 >= 57345) ? (a1 * 4) % 131072 : 98308;
        fa    = (pks1 != 0) ? fa1 : (131072 - fa1) % 131072;
        uga2b = (uga2a + fa) % 131072;
        if (sigpk != 0)          uga2 = 0;
        else if (uga2b >= 65536) uga2 = uga2b / 128 + 64512;
        else                     uga2 = uga2b / 128;
        if (a2 < 32768) ula2 = (65536 - a2 / 128) % 65536;
        else            ula2 = (65536 - (a2 / 128 + 65024)) % 65536;
        ua2 = (uga2 + ula2) % 65536;
        return 16'((a2 + ua2) % 65536);
    endfunction

    // Single compare point on the falling edge: model, optional hand literal, scan outputs.
    always @(negedge clk) begin
        if (vec_vld) begin
            mdl = model(int'(bus.PK0), int'(bus.PK1), int'(bus.PK2), int'(bus.SIGPK),
                        int'(bus.A1), int'(bus.A2));
            checks++;
            if (bus.A2T !== mdl) begin
                errors++;
                $display("FAIL %s model: A2T=%h expected %h", tag, bus.A2T, mdl);
            end
            if (lit_vld) begin
                checks++;
                if (bus.A2T !== lit_exp) begin
                    errors++;
                    $display("FAIL %s literal: A2T=%h expected %h", tag, bus.A2T, lit_exp);
                end
            end
            checks++;
            if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
                errors++;
                $display("FAIL %s scan_out: got %b expected 00000", tag,
                         {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
            end
        end
    end

    task automatic apply(input string name, input bit p0, input bit p1, input bit p2,
                         input bit sg, input logic [15:0] a1, input logic [15:0] a2,
                         input bit has_lit, input logic [15:0] lit);
        @(posedge clk);
        #1;
        bus.PK0   = p0;
        bus.PK1   = p1;
        bus.PK2   = p2;
        bus.SIGPK = sg;
        bus.A1    = a1;
        bus.A2    = a2;
        tag       = name;
        lit_vld   = has_lit;
        lit_exp   = lit;
        vec_vld   = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset       = 1'b0;
        scan_in0    = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0;
        scan_in3    = 1'b0; scan_in4 = 1'b0;
        scan_enable = 1'b0;
        test_mode   = 1'b0;
        bus.PK0 = 1'b0; bus.PK1 = 1'b0; bus.PK2 = 1'b0; bus.SIGPK = 1'b0;
        bus.A1  = 16'h0000; bus.A2 = 16'h0000;

        // Reset held low: output must still follow the inputs.
        apply("reset_state",   0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0080);
        apply("sigpk_zero",    0, 0, 0, 1, 16'h0000, 16'h0000, 1, 16'h0000);
        apply("neg_uga2",      1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'hFF80);
        apply("leak_wrap",     0, 0, 0, 0, 16'h1000, 16'h1000, 1, 16'h0FE0);
        apply("neg_leak",      0, 0, 0, 1, 16'h0000, 16'hF000, 1, 16'hF020);
        apply("a1_pos_clamp",  0, 0, 0, 0, 16'h4000, 16'h0000, 1, 16'hFF80);

        reset = 1'b1;
        // A1 boundary sweep, PKS1=1 so FA1 reaches the sum directly.
        apply("a1_8190",       1, 0, 1, 0, 16'd8190,  16'h0000, 1, 16'h017F);
        apply("a1_8191",       1, 0, 1, 0, 16'd8191,  16'h0000, 1, 16'h017F);
        apply("a1_8192",       1, 0, 1, 0, 16'd8192,  16'h0000, 1, 16'h017F);
        apply("a1_57344",      1, 0, 1, 0, 16'd57344, 16'h0000, 1, 16'hFF80);
        apply("a1_57345",      1, 0, 1, 0, 16'd57345, 16'h0000, 1, 16'hFF80);
        apply("a1_57346",      1, 0, 1, 0, 16'd57346, 16'h0000, 1, 16'hFF80);
        // Same boundaries with PKS1=0 (negated FA), model-checked.
        apply("a1_57344_neg",  0, 0, 0, 0, 16'd57344, 16'h0000, 1, 16'h017F);
        apply("a1_8191_neg",   0, 0, 1, 0, 16'd8191,  16'h1234, 0, 16'h0000);
        apply("a1_57345_neg",  0, 0, 1, 0, 16'd57345, 16'hC000, 0, 16'h0000);
        apply("a1_min",        1, 1, 0, 0, 16'h8000,  16'h7FFF, 0, 16'h0000);
        apply("a1_max",        0, 1, 1, 0, 16'h7FFF,  16'h8000, 0, 16'h0000);

        // Random sweep against the model, alternating reset level.
        for (int i = 0; i < 300; i++) begin
            reset = i[0];
            apply("random", 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(3) == 0), 16'($urandom), 16'($urandom), 0, 16'h0000);
        end

        @(posedge clk);
        vec_vld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
